// File: rtl/scan_decoder_if.sv
// scan_decoder_if: control inputs and channel outputs of scan_decoder.
// SCAN_CHMASK_EN adds the ch_mask channel-exclusion vector.
interface scan_decoder_if #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
);
  localparam int OUT_W = 1 << SEL_W;

  logic               en;
  logic               mode;
  logic [SEL_W-1:0]   a;
  logic [DWELL_W-1:0] dwell;
`ifdef SCAN_CHMASK_EN
  logic [OUT_W-1:0]   ch_mask;
`endif
  logic [OUT_W-1:0]   y;
  logic [SEL_W-1:0]   idx;
  logic               wrap;

`ifdef SCAN_CHMASK_EN
  modport master (
    output en, mode, a, dwell, ch_mask,
    input  y, idx, wrap
  );
  modport slave (
    input  en, mode, a, dwell, ch_mask,
    output y, idx, wrap
  );
`else
  modport master (
    output en, mode, a, dwell,
    input  y, idx, wrap
  );
  modport slave (
    input  en, mode, a, dwell,
    output y, idx, wrap
  );
`endif
endinterface

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot decoder with DIRECT and SCAN modes.
// Optional SCAN_CHMASK_EN enables per-channel exclusion from the scan.
module scan_decoder #(
  parameter int SEL_W      = 2,
  parameter int DWELL_W    = 8,
  parameter int ACTIVE_LOW = 0
) (
  input logic           clk,
  input logic           rst_n,
  scan_decoder_if.slave bus
);
  localparam int OUT_W = 1 << SEL_W;
  localparam logic [OUT_W-1:0] INACT =
    (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : '0;

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

  state_t             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic               wrap_q, wrap_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic               act_d;
  logic [OUT_W-1:0]   mask;
  logic               all_masked;

`ifdef SCAN_CHMASK_EN
  assign mask = bus.ch_mask;
`else
  assign mask = '0;
`endif

  assign all_masked = &mask;

  // first unmasked index strictly after cur, wrapping; cur if none other
  function automatic logic [SEL_W-1:0] next_free(
    input logic [SEL_W-1:0] cur,
    input logic [OUT_W-1:0] m
  );
    logic [SEL_W-1:0] r;
    logic [SEL_W-1:0] c;
    logic             found;
    r     = cur;
    found = 1'b0;
    for (int k = 1; k <= OUT_W; k++) begin
      c = cur + SEL_W'(k);
      if (!found && !m[c]) begin
        r     = c;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [SEL_W-1:0] lowest_free(
    input logic [OUT_W-1:0] m
  );
    logic [SEL_W-1:0] r;
    r = '0;
    for (int k = OUT_W - 1; k >= 0; k--) begin
      if (!m[k]) r = SEL_W'(k);
    end
    return r;
  endfunction

  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    idx_d   = '0;
    wrap_d  = 1'b0;
    act_d   = 1'b0;
    if (bus.en) state_d = bus.mode ? SCAN : DIRECT;
    unique case (state_d)
      IDLE: begin
      end
      DIRECT: begin
        idx_d = bus.a;
        act_d = 1'b1;
      end
      SCAN: begin
        if (state_q != SCAN) begin
          idx_d = lowest_free(mask);
          act_d = !all_masked;
        end else if (all_masked) begin
          idx_d = idx_q;
        end else if (mask[idx_q] || cnt_q >= bus.dwell) begin
          idx_d  = next_free(idx_q, mask);
          act_d  = 1'b1;
          wrap_d = idx_d < idx_q;
        end else begin
          idx_d = idx_q;
          cnt_d = cnt_q + DWELL_W'(1);
          act_d = 1'b1;
        end
      end
      default: begin
      end
    endcase
    y_d = act_d ? (OUT_W'(1) << idx_d) : '0;
    y_d = y_d ^ INACT;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      y_q     <= INACT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      y_q     <= y_d;
    end
  end

  assign bus.y    = y_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed and random stimulus against a
// cycle-level behavioural model of the scan decoder.
module tb_scan_decoder;
  localparam int SEL_W = 2;
  localparam int DW    = 8;
  localparam int AL    = 0;
  localparam int OUT_W = 1 << SEL_W;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // model state: channel shown, cycles it has been shown, scanning flag
  int   m_on, m_ch, m_age, m_scan, m_wrap;

  scan_decoder_if #(.SEL_W(SEL_W), .DWELL_W(DW)) bus ();

  scan_decoder #(
    .SEL_W(SEL_W),
    .DWELL_W(DW),
    .ACTIVE_LOW(AL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input logic m,
                       input int aa, input int d);
    bus.en    = e;
    bus.mode  = m;
    bus.a     = SEL_W'(aa);
    bus.dwell = DW'(d);
  endtask

  task automatic model_edge();
    if (!rst_n || !bus.en) begin
      m_on = 0; m_ch = 0; m_age = 0; m_wrap = 0; m_scan = 0;
    end else if (!bus.mode) begin
      m_on = 1; m_ch = int'(bus.a); m_age = 0;
      m_wrap = 0; m_scan = 0;
    end else if (m_scan == 0) begin
      m_scan = 1; m_on = 1; m_ch = 0; m_age = 0; m_wrap = 0;
    end else if (m_age >= int'(bus.dwell)) begin
      m_ch   = (m_ch + 1) % OUT_W;
      m_age  = 0;
      m_wrap = (m_ch == 0) ? 1 : 0;
    end else begin
      m_age++;
      m_wrap = 0;
    end
  endtask

  task automatic step(input string tag);
    int ey;
    int ny;
    @(posedge clk);
    model_edge();
    #1;
    ey = (m_on != 0) ? (1 << m_ch) : 0;
    if (AL != 0) ey = ey ^ ((1 << OUT_W) - 1);
    ny = (AL != 0) ? int'($countones(~bus.y)) : int'($countones(bus.y));
    chk({tag, ".y"}, int'(bus.y), ey);
    chk({tag, ".idx"}, int'(bus.idx), m_ch);
    chk({tag, ".wrap"}, int'(bus.wrap), m_wrap);
    chk({tag, ".onehot"}, int'(ny <= 1), 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_on = 0; m_ch = 0; m_age = 0; m_scan = 0; m_wrap = 0;
`ifdef SCAN_CHMASK_EN
    bus.ch_mask = '0;
`endif
    rst_n = 1'b0;
    drive(1, 1, 0, 0);
    step("rst0");
    step("rst1");
    chk("rst.y_zero", int'(bus.y), 0);
    rst_n = 1'b1;

    for (int i = 0; i < OUT_W; i++) begin
      drive(1, 0, i, 0);
      step("direct");
      chk("direct.onehot_a", int'(bus.y), 1 << i);
    end
    drive(0, 0, 3, 0);
    step("direct_off");

    drive(1, 1, 0, 2);
    for (int i = 0; i < 14; i++) step("scan_d2");
    chk("scan_d2.wrap_idx0", int'(bus.idx), 0);

    drive(0, 1, 0, 0);
    step("gap");
    drive(1, 1, 0, 0);
    for (int i = 0; i < 9; i++) step("scan_d0");

    drive(0, 1, 0, 5);
    step("gap2");
    drive(1, 1, 0, 5);
    for (int i = 0; i < 4; i++) step("scan_d5");
    bus.dwell = DW'(1);
    step("dwell_drop");
    chk("dwell_drop.adv", int'(bus.idx), 1);

    drive(0, 1, 0, 0);
    step("gap3");
    drive(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("pre_rst");
    chk("pre_rst.idx2", int'(bus.idx), 2);
    rst_n = 1'b0;
    step("mid_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step("post_rst");
    bus.en = 1'b0;
    step("en_drop");
    bus.en = 1'b1;
    step("reenable");
    chk("reenable.nowrap", int'(bus.wrap), 0);
    chk("reenable.idx0", int'(bus.idx), 0);

    bus.mode = 1'b0;
    bus.a    = SEL_W'(2);
    step("scan2direct");

    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      bus.en    = ($urandom_range(0, 9) != 0);
      bus.mode  = ($urandom_range(0, 4) != 0);
      bus.a     = SEL_W'($urandom_range(0, OUT_W - 1));
      bus.dwell = DW'($urandom_range(0, 4));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
